// File: rtl/spike_detector_pkg.sv
// -----------------------------------------------------------------------------
// spike_detector_pkg
//   Shared definitions for the spike detector: the detector FSM encoding, the
//   width of every event counter, and the saturating increment used by both
//   the lifetime spike counter and the per-window rate counter.
//   No ports (package).
// -----------------------------------------------------------------------------
package spike_detector_pkg;

   localparam int COUNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,   // waiting for the first above-threshold sample
      ARM     = 2'd1,   // counting consecutive above samples
      REFRACT = 2'd2,   // dead time after a spike, input ignored
      REARM   = 2'd3    // refractory done but excursion still ongoing
   } state_t;

   // Counts up but sticks at all-ones instead of wrapping to zero.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
      return (value == {COUNT_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/spike_detector_rate.sv
// -----------------------------------------------------------------------------
// rate_window
//   Free-running window counter 0..WINDOW_CYCLES-1. Spikes inside a window are
//   accumulated (saturating); on the wrap edge the total is published on
//   rateOut with a one-cycle rateValid pulse and the accumulator restarts.
//
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-low
//   spike     in   spike event decided on this edge (counted on this edge)
//   rateOut   out  spikes in the last completed window
//   rateValid out  one-cycle pulse when rateOut updates
// -----------------------------------------------------------------------------
module rate_window
   import spike_detector_pkg::*;
#(
   parameter int WINDOW_CYCLES = 104000
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               spike,
   output logic [COUNT_W-1:0] rateOut,
   output logic               rateValid
);

   localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   logic [WIN_W-1:0]   win_cnt_reg;
   logic [COUNT_W-1:0] win_spikes_reg;
   logic [COUNT_W-1:0] win_spikes_next;

   // Includes a spike decided on the wrap edge itself, so no event is lost
   // between the closing and the opening window.
   assign win_spikes_next = spike ? sat_inc(win_spikes_reg) : win_spikes_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_cnt_reg    <= '0;
         win_spikes_reg <= '0;
         rateOut        <= '0;
         rateValid      <= 1'b0;
      end else if (win_cnt_reg == WIN_LAST) begin
         win_cnt_reg    <= '0;
         win_spikes_reg <= '0;
         rateOut        <= win_spikes_next;
         rateValid      <= 1'b1;
      end else begin
         win_cnt_reg    <= win_cnt_reg + 1'b1;
         win_spikes_reg <= win_spikes_next;
         rateValid      <= 1'b0;
      end
   end

endmodule

// File: rtl/spike_detector.sv
// -----------------------------------------------------------------------------
// spike_detector
//   Turns a registered comparator "above threshold" flag into clean spike
//   events: CONFIRM_CYCLES consecutive above samples fire one spike, followed
//   by REFRACTORY_CYCLES of dead time; a sustained excursion fires only once.
//   Keeps a saturating lifetime spike count and a per-window spike rate.
//
//   CLK104MHZ  in   single clock, rising edge
//   RESETN     in   asynchronous, active-low reset
//   Gt         in   comparator above flag (the only flag that matters)
//   Eq, Lt     in   comparator equal/below flags (both mean "not above")
//   clrCount   in   synchronous clear of spikeCount, wins over a spike
//   spike      out  one-cycle registered spike pulse
//   busy       out  high in REFRACT or REARM
//   spikeCount out  saturating spike total since reset/clear
//   rateOut    out  spikes in the last completed window
//   rateValid  out  one-cycle pulse when rateOut updates
// -----------------------------------------------------------------------------
module spike_detector
   import spike_detector_pkg::*;
#(
   parameter int CONFIRM_CYCLES    = 4,
   parameter int REFRACTORY_CYCLES = 1040,
   parameter int WINDOW_CYCLES     = 104000
)(
   input  logic               CLK104MHZ,
   input  logic               RESETN,
   input  logic               Gt,
   input  logic               Eq,
   input  logic               Lt,
   input  logic               clrCount,
   output logic               spike,
   output logic               busy,
   output logic [COUNT_W-1:0] spikeCount,
   output logic [COUNT_W-1:0] rateOut,
   output logic               rateValid
);

   localparam logic [7:0]  RUN_LAST  = 8'(CONFIRM_CYCLES - 1);
   localparam logic [15:0] REFR_LOAD = 16'(REFRACTORY_CYCLES);

   state_t             state_reg, state_next;
   logic [7:0]         run_reg, run_next;
   logic [15:0]        refr_reg, refr_next;
   logic               spike_reg;
   logic [COUNT_W-1:0] count_reg, count_next;
   logic               fire;
   logic               above;
   logic               unused_cmp;

   // Gt alone decides; an illegal Gt&Lt still counts as above.
   assign above = Gt;

   // Eq and Lt carry no information beyond !Gt for this detector.
   assign unused_cmp = &{1'b0, Eq, Lt};

   always_comb begin
      state_next = state_reg;
      run_next   = run_reg;
      refr_next  = refr_reg;
      fire       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (above) begin
               if (CONFIRM_CYCLES == 1) begin
                  fire = 1'b1;
               end else begin
                  state_next = ARM;
                  run_next   = 8'd1;
               end
            end
         end
         ARM: begin
            if (!above) begin
               state_next = IDLE;
               run_next   = '0;
            end else if (run_reg == RUN_LAST) begin
               fire = 1'b1;
            end else begin
               run_next = run_reg + 1'b1;
            end
         end
         REFRACT: begin
            // Counter was loaded on the spike edge, so reaching 1 marks the
            // last refractory cycle; the decision edge samples Gt afresh.
            if (refr_reg <= 16'd1) begin
               state_next = above ? REARM : IDLE;
               refr_next  = '0;
            end else begin
               refr_next = refr_reg - 1'b1;
            end
         end
         REARM: begin
            if (!above) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (fire) begin
         state_next = REFRACT;
         run_next   = '0;
         refr_next  = REFR_LOAD;
      end
   end

   always_comb begin
      count_next = count_reg;
      if (clrCount)  count_next = '0;
      else if (fire) count_next = sat_inc(count_reg);
   end

   always_ff @(posedge CLK104MHZ or negedge RESETN) begin
      if (!RESETN) begin
         state_reg <= IDLE;
         run_reg   <= '0;
         refr_reg  <= '0;
         spike_reg <= 1'b0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         run_reg   <= run_next;
         refr_reg  <= refr_next;
         spike_reg <= fire;
         count_reg <= count_next;
      end
   end

   assign spike      = spike_reg;
   assign busy       = (state_reg == REFRACT) || (state_reg == REARM);
   assign spikeCount = count_reg;

   rate_window #(
      .WINDOW_CYCLES (WINDOW_CYCLES)
   ) u_rate (
      .clk       (CLK104MHZ),
      .reset     (RESETN),
      .spike     (fire),
      .rateOut   (rateOut),
      .rateValid (rateValid)
   );

endmodule
